// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: Funct3 encodings, FSM states
// and the store byte-lane decoder.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Byte lanes touched by a store of the given size at the given byte offset.
    function automatic logic [3:0] lane_en(input logic [2:0] funct3, input logic [1:0] addr);
        logic [3:0] en;
        en = 4'b0000;
        case (funct3)
            F3_B:    en = 4'b0001 << addr;
            F3_H:    en = addr[1] ? 4'b1100 : 4'b0011;
            F3_W:    en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response bundle; the core is the master.
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        RdValid;
    logic        Stall;
    logic        MisalignErr;

    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, RdValid, Stall, MisalignErr
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, RdValid, Stall, MisalignErr
    );
endinterface

// File: rtl/dmem_responder_bank.sv
// Word-organised RAM with per-byte write enables, synchronous write and
// asynchronous read on a shared address. Contents are never reset.
module dmem_bank #(
    parameter  int DEPTH_WORDS = 128,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[l]) begin
                mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, stalls the pipeline for
// LATENCY cycles, then retires it with a one-cycle RdValid pulse.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    dmem_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic [AW+1:0] addr_q;
    logic [2:0]    f3_q;
    logic [31:0]   wdata_q;
    logic          store_q;
    logic          err_q;
    logic [31:0]   rd_data_q;
    logic          rd_valid_q;
    logic          misalign_q;

    logic          req_s;
    logic          idle_s;
    logic          err_in_s;
    logic [AW+1:0] cur_addr_s;
    logic [2:0]    cur_f3_s;
    logic [31:0]   cur_wdata_s;
    logic          cur_store_s;
    logic          cur_err_s;
    logic          to_resp_s;
    logic [3:0]    we_s;
    logic [31:0]   wr_lanes_s;
    logic [31:0]   rdata_s;
    logic [31:0]   shifted_s;
    logic [31:0]   rsp_data_d;
    logic          unused_addr_s;

    assign req_s         = bus.MemRead | bus.MemWrite;
    assign idle_s        = (state_q == IDLE);
    assign unused_addr_s = ^bus.Addr[31:AW+2];

    // In IDLE the live request is what gets committed (LATENCY=1 goes straight to RESP);
    // afterwards only the captured copy matters.
    assign cur_addr_s  = idle_s ? bus.Addr[AW+1:0] : addr_q;
    assign cur_f3_s    = idle_s ? bus.Funct3       : f3_q;
    assign cur_wdata_s = idle_s ? bus.WrData       : wdata_q;
    assign cur_store_s = idle_s ? bus.MemWrite     : store_q;
    assign cur_err_s   = idle_s ? err_in_s         : err_q;

    // Classify the live request: simultaneous read+write, illegal size code, or misalignment.
    always_comb begin
        err_in_s = 1'b0;
        if (bus.MemRead && bus.MemWrite) begin
            err_in_s = 1'b1;
        end else begin
            case (bus.Funct3)
                F3_B:         err_in_s = 1'b0;
                F3_H:         err_in_s = bus.Addr[0];
                F3_W:         err_in_s = (bus.Addr[1:0] != 2'b00);
                F3_BU:        err_in_s = bus.MemWrite;
                F3_HU:        err_in_s = bus.MemWrite | bus.Addr[0];
                default:      err_in_s = 1'b1;
            endcase
        end
    end

    assign to_resp_s = req_s & ((idle_s & (LATENCY == 1)) |
                                ((state_q == BUSY) & (cnt_q == CW'(1))));

    assign we_s = (to_resp_s & cur_store_s & ~cur_err_s & ~reset)
                  ? lane_en(cur_f3_s, cur_addr_s[1:0]) : 4'b0000;

    // Replicate right-aligned store data onto every lane it could land in.
    always_comb begin
        wr_lanes_s = cur_wdata_s;
        case (cur_f3_s)
            F3_B:    wr_lanes_s = {4{cur_wdata_s[7:0]}};
            F3_H:    wr_lanes_s = {2{cur_wdata_s[15:0]}};
            default: wr_lanes_s = cur_wdata_s;
        endcase
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk     (clk),
        .we_i    (we_s),
        .addr_i  (cur_addr_s[AW+1:2]),
        .wdata_i (wr_lanes_s),
        .rdata_o (rdata_s)
    );

    // Load extraction and extension; stores and dropped accesses return zero.
    always_comb begin
        shifted_s  = rdata_s >> {cur_addr_s[1:0], 3'b000};
        rsp_data_d = 32'h0000_0000;
        if (!cur_store_s && !cur_err_s) begin
            case (cur_f3_s)
                F3_B:    rsp_data_d = {{24{shifted_s[7]}}, shifted_s[7:0]};
                F3_H:    rsp_data_d = {{16{shifted_s[15]}}, shifted_s[15:0]};
                F3_W:    rsp_data_d = rdata_s;
                F3_BU:   rsp_data_d = {24'h00_0000, shifted_s[7:0]};
                F3_HU:   rsp_data_d = {16'h0000, shifted_s[15:0]};
                default: rsp_data_d = 32'h0000_0000;
            endcase
        end else begin
            rsp_data_d = 32'h0000_0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            f3_q       <= 3'b000;
            wdata_q    <= 32'h0000_0000;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 32'h0000_0000;
            rd_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rd_data_q  <= 32'h0000_0000;
            rd_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        addr_q  <= bus.Addr[AW+1:0];
                        f3_q    <= bus.Funct3;
                        wdata_q <= bus.WrData;
                        store_q <= bus.MemWrite;
                        err_q   <= err_in_s;
                        cnt_q   <= CNT_INIT;
                        if (to_resp_s) begin
                            state_q    <= RESP;
                            rd_data_q  <= rsp_data_d;
                            rd_valid_q <= 1'b1;
                            misalign_q <= err_in_s;
                        end else begin
                            state_q <= BUSY;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                    end else if (to_resp_s) begin
                        state_q    <= RESP;
                        cnt_q      <= '0;
                        rd_data_q  <= rsp_data_d;
                        rd_valid_q <= 1'b1;
                        misalign_q <= err_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Stall       = req_s & (state_q != RESP);
    assign bus.RdData      = rd_data_q;
    assign bus.RdValid     = rd_valid_q;
    assign bus.MisalignErr = misalign_q;

endmodule
